dbus_req_arbiter: RTL and testbench
===================================

# dbus_req_arbiter

Front end of the bus controller. It arbitrates dcache bus requests from two cores round-robin into an 8-entry in-order request queue. Each queue-head request is issued to the bus controller only when no in-flight transaction targets the same block. In-flight blocks are tracked in the static 2-way conflict table: 8 sets, with way 1 indexed by lower index XOR upper index.

## Interface
Parameters:
- NUM_CORES, 2, number of requesting dcaches; the design is fixed at 2.
- Q_DEPTH, BUS_CONTROLLER_DBUS_REQ_Q_DEPTH (8), request queue entries.
- CT_SETS, BUS_CONTROLLER_CONFLICT_TABLE_NUM_SETS (8), conflict table sets per way.

Ports (BAW = BLOCK_ADDR_SPACE_WIDTH):
- CLK  in  1  single clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- core_req_valid  in  2  per-core request valid.
- core_req_block_addr  in  2×BAW  per-core block address.
- core_req_exclusive  in  2  1 = BusRdX/upgrade, 0 = BusRd.
- core_req_ready  out  2  per-core accept, one-hot or zero.
- bus_req_valid  out  1  head request issuable.
- bus_req_core  out  1  issuing core id.
- bus_req_block_addr  out  BAW  issued block address.
- bus_req_exclusive  out  1  issued request type.
- bus_req_ready  in  1  bus controller accepts the issue.
- bus_done_valid  in  1  transaction completed.
- bus_done_block_addr  in  BAW  block address of the completed transaction.
- conflict_stall  out  1  head valid but blocked by a hit or a full set.

## Operation
- **Enqueue:** at most one request per cycle.
  - A request is accepted only when count < Q_DEPTH. When the queue is full, no request is accepted, even if a dequeue occurs in the same cycle.
  - Both cores valid: grant the core `rr` points to, then `rr` ← other core.
  - One core valid: grant it, then `rr` ← other core.
  - No grant: `rr` holds.
- **Queue:** circular FIFO with head/tail pointers that wrap modulo 8 and a 4-bit count (0..8). There is no bypass; an empty queue issues nothing.
- **Conflict lookup on the head entry:**
  - set0 = lower_index, set1 = lower_index ^ upper_index, using the conflict_table_block_addr_t split.
  - Hit = way0[set0] valid with matching full block address, OR way1[set1] valid with matching full block address.
  - Free way = way0[set0] if it is invalid, else way1[set1] if it is invalid, else none.
- **Issue:** bus_req_valid = !empty && !hit && free way exists.
  - conflict_stall = !empty && (hit || no free way).
  - The head is head-of-line blocking; younger entries never bypass it.
- **Dequeue:** on bus_req_valid && bus_req_ready:
  - pop the head;
  - allocate the chosen free way with {valid=1, block_addr}.
- **Completion:** bus_done_valid invalidates the way (0 or 1) holding bus_done_block_addr.
  - A done for an absent address is ignored and flagged by a simulation assertion.
- **Simultaneous done and allocate:** both apply in the same cycle. Allocation targets only an invalid way, so the two never collide. The issue decision uses registered table state, so a slot freed by a done this cycle becomes usable next cycle.
- **Reset:** queue empty, all table entries invalid, rr = 0, all outputs 0.

## Timing
- core_req_ready is combinational from core_req_valid, count and rr.
- bus_req_* and conflict_stall are combinational from registered state only.
- Accept at cycle t → bus_req_valid at t+1 at the earliest.
- Done at cycle t for a stalled head's block → head issues at t+1.
- bus_req_* hold stable while bus_req_valid && !bus_req_ready. The state cannot change in that case, except that a done may newly free a way.
- nRST asserted mid-operation discards queued requests and in-flight table entries immediately (asynchronous).

## Structure
- Add to mem_types_pkg:
  - `dbus_req_t` = {core, exclusive, block_addr};
  - `conflict_table_entry_t` = {valid, block_addr};
  - `NUM_CORES = 2`.
- Sub-module `bus_controller_conflict_table` implements the two ways × 8 sets of entries, lookup, free-way select, allocate and done-invalidate.
- The FIFO and the round-robin arbitration stay in the top module.

## Test plan
- **Round-robin, no conflicts:** both cores valid with 0x10 / 0x20 for 4 cycles, rr = 0 → grants alternate core0, core1, core0, core1; bus_req_ready = 1 → issue order 0x10, 0x20, 0x10 stalls (hit) until done(0x10).
- **Conflict stall:** issue 0x05, then enqueue 0x05 from core1 → conflict_stall = 1 and bus_req_valid = 0; done(0x05) at t → bus_req_valid = 1 at t+1.
- **Set-full stall:** issue two distinct blocks that both map to set0 = 3 and set1 = 3 (way0 then way1), then a third mapping the same way → stall; done on the way1 block → third issues into way1.
- **Full queue:** bus_req_ready = 0, 9 requests presented → 8 accepted, core_req_ready = 0 on the 9th, including the cycle where bus_req_ready rises. Pointers wrap correctly over 20 further requests.
- **Simultaneous done and issue:** allocate way0[2] while done frees way1[6] in the same cycle → both entries are updated correctly.
- **Reset:** assert nRST with 5 queued requests and 3 in flight → all outputs 0 at once; after release a new request issues at t+1 with no false conflict.

Source files
------------

// File: rtl/dbus_req_arbiter_pkg.sv
// Shared types for the dcache bus request front end: queued request format, conflict table
// entry layout and the block-address split used to index the two table ways.
package dbus_req_arbiter_pkg;

    localparam int unsigned BLOCK_ADDR_SPACE_WIDTH                 = 12;
    localparam int unsigned NUM_CORES                              = 2;
    localparam int unsigned BUS_CONTROLLER_DBUS_REQ_Q_DEPTH        = 8;
    localparam int unsigned BUS_CONTROLLER_CONFLICT_TABLE_NUM_SETS = 8;

    localparam int unsigned CT_INDEX_WIDTH = $clog2(BUS_CONTROLLER_CONFLICT_TABLE_NUM_SETS);
    localparam int unsigned CT_TAG_WIDTH   = BLOCK_ADDR_SPACE_WIDTH - 2 * CT_INDEX_WIDTH;

    typedef logic [BLOCK_ADDR_SPACE_WIDTH-1:0] block_addr_t;
    typedef logic [CT_INDEX_WIDTH-1:0]         ct_index_t;

    typedef struct packed {
        logic [CT_TAG_WIDTH-1:0]   tag;
        logic [CT_INDEX_WIDTH-1:0] upper_index;
        logic [CT_INDEX_WIDTH-1:0] lower_index;
    } conflict_table_block_addr_t;

    typedef struct packed {
        logic        core;
        logic        exclusive;
        block_addr_t block_addr;
    } dbus_req_t;

    typedef struct packed {
        logic        valid;
        block_addr_t block_addr;
    } conflict_table_entry_t;

    function automatic ct_index_t ct_set0(input block_addr_t addr);
        conflict_table_block_addr_t split;
        split = addr;
        return split.lower_index;
    endfunction

    // Way 1 is skewed so blocks that collide in way 0 usually spread out here.
    function automatic ct_index_t ct_set1(input block_addr_t addr);
        conflict_table_block_addr_t split;
        split = addr;
        return split.lower_index ^ split.upper_index;
    endfunction

endpackage

// File: rtl/bus_controller_conflict_table.sv
// Two-way skewed table of in-flight bus transactions: lookup/free-way select for the queue
// head, allocation on issue and invalidation on completion.
module bus_controller_conflict_table
    import dbus_req_arbiter_pkg::*;
#(
    parameter int unsigned CT_SETS = BUS_CONTROLLER_CONFLICT_TABLE_NUM_SETS
) (
    input  logic        CLK,
    input  logic        nRST,
    input  block_addr_t lookup_addr_i,
    output logic        hit_o,
    output logic        free_valid_o,
    output logic        free_way_o,
    input  logic        alloc_i,
    input  logic        alloc_way_i,
    input  block_addr_t alloc_addr_i,
    input  logic        done_valid_i,
    input  block_addr_t done_addr_i
);

    conflict_table_entry_t way0_q [CT_SETS];
    conflict_table_entry_t way1_q [CT_SETS];
    conflict_table_entry_t way0_d [CT_SETS];
    conflict_table_entry_t way1_d [CT_SETS];

    ct_index_t look_set0, look_set1;
    ct_index_t alloc_set0, alloc_set1;
    ct_index_t done_set0, done_set1;
    logic      look_hit0, look_hit1;
    logic      done_hit0, done_hit1, done_hit;

    always_comb begin
        look_set0  = ct_set0(lookup_addr_i);
        look_set1  = ct_set1(lookup_addr_i);
        alloc_set0 = ct_set0(alloc_addr_i);
        alloc_set1 = ct_set1(alloc_addr_i);
        done_set0  = ct_set0(done_addr_i);
        done_set1  = ct_set1(done_addr_i);

        look_hit0 = way0_q[look_set0].valid && (way0_q[look_set0].block_addr == lookup_addr_i);
        look_hit1 = way1_q[look_set1].valid && (way1_q[look_set1].block_addr == lookup_addr_i);
        hit_o     = look_hit0 || look_hit1;

        free_valid_o = !way0_q[look_set0].valid || !way1_q[look_set1].valid;
        free_way_o   = way0_q[look_set0].valid;

        done_hit0 = way0_q[done_set0].valid && (way0_q[done_set0].block_addr == done_addr_i);
        done_hit1 = way1_q[done_set1].valid && (way1_q[done_set1].block_addr == done_addr_i);
        done_hit  = done_hit0 || done_hit1;
    end

    // Allocation only ever targets an invalid way and a done only a valid one, so both may
    // apply in the same cycle without ordering concerns.
    always_comb begin
        way0_d = way0_q;
        way1_d = way1_q;
        if (done_valid_i) begin
            if (done_hit0) begin
                way0_d[done_set0].valid = 1'b0;
            end else if (done_hit1) begin
                way1_d[done_set1].valid = 1'b0;
            end
        end
        if (alloc_i) begin
            if (!alloc_way_i) begin
                way0_d[alloc_set0] = '{valid: 1'b1, block_addr: alloc_addr_i};
            end else begin
                way1_d[alloc_set1] = '{valid: 1'b1, block_addr: alloc_addr_i};
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < int'(CT_SETS); s++) begin
                way0_q[s] <= '0;
                way1_q[s] <= '0;
            end
        end else begin
            way0_q <= way0_d;
            way1_q <= way1_d;
        end
    end

    done_known_a: assert property (@(posedge CLK) disable iff (!nRST) done_valid_i |-> done_hit);

endmodule

// File: rtl/dbus_req_arbiter.sv
// Round-robin arbiter of two dcache bus request streams into an in-order queue whose head
// issues only when no in-flight transaction targets the same block.
module dbus_req_arbiter #(
    parameter int unsigned NUM_CORES = dbus_req_arbiter_pkg::NUM_CORES,
    parameter int unsigned Q_DEPTH   = dbus_req_arbiter_pkg::BUS_CONTROLLER_DBUS_REQ_Q_DEPTH,
    parameter int unsigned CT_SETS   =
        dbus_req_arbiter_pkg::BUS_CONTROLLER_CONFLICT_TABLE_NUM_SETS
) (
    input  logic                                   CLK,
    input  logic                                   nRST,
    input  logic [NUM_CORES-1:0]                   core_req_valid_i,
    input  logic [NUM_CORES-1:0][dbus_req_arbiter_pkg::BLOCK_ADDR_SPACE_WIDTH-1:0]
                                                   core_req_block_addr_i,
    input  logic [NUM_CORES-1:0]                   core_req_exclusive_i,
    output logic [NUM_CORES-1:0]                   core_req_ready_o,
    output logic                                   bus_req_valid_o,
    output logic                                   bus_req_core_o,
    output dbus_req_arbiter_pkg::block_addr_t      bus_req_block_addr_o,
    output logic                                   bus_req_exclusive_o,
    input  logic                                   bus_req_ready_i,
    input  logic                                   bus_done_valid_i,
    input  dbus_req_arbiter_pkg::block_addr_t      bus_done_block_addr_i,
    output logic                                   conflict_stall_o
);
    import dbus_req_arbiter_pkg::*;

    localparam int unsigned PtrW = $clog2(Q_DEPTH);
    localparam int unsigned CntW = $clog2(Q_DEPTH + 1);

    dbus_req_t       queue_q [Q_DEPTH];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            rr_q, rr_d;

    logic      full, empty, accept, grant_core, fire;
    dbus_req_t enq_req, head_req;
    logic      ct_hit, ct_free_valid, ct_free_way;

    // Arbitration: full blocks acceptance even when a dequeue happens this cycle.
    always_comb begin
        full   = (count_q == CntW'(Q_DEPTH));
        empty  = (count_q == '0);
        accept = !full && (|core_req_valid_i);

        if (&core_req_valid_i) begin
            grant_core = rr_q;
        end else begin
            grant_core = core_req_valid_i[1];
        end

        core_req_ready_o = '0;
        if (accept) begin
            core_req_ready_o[grant_core] = 1'b1;
        end
        rr_d = accept ? ~grant_core : rr_q;

        enq_req = '{core:       grant_core,
                    exclusive:  core_req_exclusive_i[grant_core],
                    block_addr: core_req_block_addr_i[grant_core]};
    end

    always_comb begin
        head_req             = queue_q[head_q];
        bus_req_valid_o      = !empty && !ct_hit && ct_free_valid;
        conflict_stall_o     = !empty && (ct_hit || !ct_free_valid);
        bus_req_core_o       = head_req.core;
        bus_req_exclusive_o  = head_req.exclusive;
        bus_req_block_addr_o = head_req.block_addr;
        fire                 = bus_req_valid_o && bus_req_ready_i;
    end

    always_comb begin
        tail_d  = accept ? tail_q + PtrW'(1) : tail_q;
        head_d  = fire ? head_q + PtrW'(1) : head_q;
        count_d = count_q + CntW'(accept) - CntW'(fire);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rr_q    <= 1'b0;
            for (int i = 0; i < int'(Q_DEPTH); i++) begin
                queue_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rr_q    <= rr_d;
            if (accept) begin
                queue_q[tail_q] <= enq_req;
            end
        end
    end

    bus_controller_conflict_table #(
        .CT_SETS (CT_SETS)
    ) u_conflict_table (
        .CLK           (CLK),
        .nRST          (nRST),
        .lookup_addr_i (head_req.block_addr),
        .hit_o         (ct_hit),
        .free_valid_o  (ct_free_valid),
        .free_way_o    (ct_free_way),
        .alloc_i       (fire),
        .alloc_way_i   (ct_free_way),
        .alloc_addr_i  (head_req.block_addr),
        .done_valid_i  (bus_done_valid_i),
        .done_addr_i   (bus_done_block_addr_i)
    );

endmodule

// File: tb/tb_dbus_req_arbiter.sv
// Scoreboard bench: a monitor models arbitration, pushes expected issues on accept and pops
// them when the DUT issues; directed scenarios check stalls, wrap and reset.
module tb_dbus_req_arbiter;
    import dbus_req_arbiter_pkg::*;

    localparam int unsigned BAW = BLOCK_ADDR_SPACE_WIDTH;

    logic                CLK = 1'b0;
    logic                nRST = 1'b0;
    logic [1:0]          core_req_valid = '0;
    logic [1:0][BAW-1:0] core_req_block_addr = '0;
    logic [1:0]          core_req_exclusive = '0;
    logic [1:0]          core_req_ready;
    logic                bus_req_valid;
    logic                bus_req_core;
    logic [BAW-1:0]      bus_req_block_addr;
    logic                bus_req_exclusive;
    logic                bus_req_ready = 1'b0;
    logic                bus_done_valid = 1'b0;
    logic [BAW-1:0]      bus_done_block_addr = '0;
    logic                conflict_stall;

    int n_tests  = 0;
    int n_failed = 0;

    logic [BAW+1:0] sb_q[$];
    logic [BAW-1:0] flight_q[$];
    int             m_count = 0;
    logic           m_rr = 1'b0;
    bit             auto_done = 1'b0;

    always #5 CLK = ~CLK;

    dbus_req_arbiter u_dut (
        .CLK                   (CLK),
        .nRST                  (nRST),
        .core_req_valid_i      (core_req_valid),
        .core_req_block_addr_i (core_req_block_addr),
        .core_req_exclusive_i  (core_req_exclusive),
        .core_req_ready_o      (core_req_ready),
        .bus_req_valid_o       (bus_req_valid),
        .bus_req_core_o        (bus_req_core),
        .bus_req_block_addr_o  (bus_req_block_addr),
        .bus_req_exclusive_o   (bus_req_exclusive),
        .bus_req_ready_i       (bus_req_ready),
        .bus_done_valid_i      (bus_done_valid),
        .bus_done_block_addr_i (bus_done_block_addr),
        .conflict_stall_o      (conflict_stall)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model of arbitration and queue occupancy, sampled mid-cycle.
    always @(negedge CLK) begin
        logic [1:0]     exp_rdy;
        logic           g;
        logic           f;
        logic [BAW+1:0] e;
        if (!nRST) begin
            sb_q.delete();
            flight_q.delete();
            m_count = 0;
            m_rr    = 1'b0;
        end else begin
            exp_rdy = '0;
            g       = 1'b0;
            if (m_count < 8 && core_req_valid != 2'b00) begin
                g = (core_req_valid == 2'b11) ? m_rr : core_req_valid[1];
                exp_rdy[g] = 1'b1;
            end
            check_eq("core_req_ready", 32'(core_req_ready), 32'(exp_rdy));
            f = bus_req_valid && bus_req_ready;
            if (f) begin
                if (sb_q.size() == 0) begin
                    check_eq("issue_unexpected", 32'(bus_req_block_addr), 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("issue_order",
                             32'({bus_req_core, bus_req_exclusive, bus_req_block_addr}), 32'(e));
                end
                flight_q.push_back(bus_req_block_addr);
            end
            if (exp_rdy != 2'b00) begin
                sb_q.push_back({g, core_req_exclusive[g], core_req_block_addr[g]});
                m_rr = ~g;
                m_count++;
            end
            if (f) m_count--;
        end
    end

    always @(posedge CLK) begin
        #1;
        if (auto_done) begin
            if (flight_q.size() != 0) begin
                bus_done_valid      = 1'b1;
                bus_done_block_addr = flight_q.pop_front();
            end else begin
                bus_done_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [BAW-1:0] a0, input logic [BAW-1:0] a1,
                         input logic [1:0] x);
        core_req_valid         = v;
        core_req_block_addr[0] = a0;
        core_req_block_addr[1] = a1;
        core_req_exclusive     = x;
    endtask

    task automatic idle();
        core_req_valid = 2'b00;
    endtask

    task automatic done_pulse(input logic [BAW-1:0] a);
        bus_done_valid      = 1'b1;
        bus_done_block_addr = a;
        tick();
        bus_done_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((m_count != 0 || flight_q.size() != 0) && k < 300) begin
            tick();
            k++;
        end
        tick();
        check_eq("drain_count", 32'(m_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] v;
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_bus_valid", 32'(bus_req_valid), 32'd0);
        check_eq("rst_stall", 32'(conflict_stall), 32'd0);
        check_eq("rst_addr", 32'(bus_req_block_addr), 32'd0);
        nRST = 1'b1;
        tick();

        // Round-robin with a repeated block that must wait for its own completion.
        bus_req_ready = 1'b1;
        drive(2'b11, 12'h010, 12'h020, 2'b00);
        repeat (4) tick();
        idle();
        tick();
        check_eq("t1_stall_hit", 32'(conflict_stall), 32'd1);
        check_eq("t1_valid_low", 32'(bus_req_valid), 32'd0);
        check_eq("t1_head_addr", 32'(bus_req_block_addr), 32'h010);
        done_pulse(12'h010);
        check_eq("t1_issue_after_done", 32'(bus_req_valid), 32'd1);
        tick();
        check_eq("t1_stall_0x20", 32'(conflict_stall), 32'd1);
        done_pulse(12'h020);
        check_eq("t1_issue_0x20", 32'(bus_req_valid), 32'd1);
        tick();
        done_pulse(12'h010);
        done_pulse(12'h020);

        // Same block from the other core.
        drive(2'b01, 12'h005, 12'h000, 2'b01);
        tick();
        drive(2'b10, 12'h000, 12'h005, 2'b00);
        tick();
        idle();
        tick();
        check_eq("t2_stall", 32'(conflict_stall), 32'd1);
        check_eq("t2_valid_low", 32'(bus_req_valid), 32'd0);
        done_pulse(12'h005);
        check_eq("t2_issue_next_cycle", 32'(bus_req_valid), 32'd1);
        tick();
        done_pulse(12'h005);

        // Both ways of set 3 occupied.
        drive(2'b01, 12'h003, 12'h000, 2'b00);
        tick();
        drive(2'b10, 12'h000, 12'h043, 2'b10);
        tick();
        drive(2'b01, 12'h083, 12'h000, 2'b00);
        tick();
        idle();
        tick();
        check_eq("t3_set_full_stall", 32'(conflict_stall), 32'd1);
        check_eq("t3_valid_low", 32'(bus_req_valid), 32'd0);
        check_eq("t3_head_addr", 32'(bus_req_block_addr), 32'h083);
        done_pulse(12'h043);
        check_eq("t3_issue_way1", 32'(bus_req_valid), 32'd1);
        tick();
        drive(2'b10, 12'h000, 12'h043, 2'b00);
        tick();
        idle();
        check_eq("t3_full_again", 32'(conflict_stall), 32'd1);
        done_pulse(12'h083);
        check_eq("t3_reissue", 32'(bus_req_valid), 32'd1);
        tick();
        done_pulse(12'h003);
        done_pulse(12'h043);

        // Full queue, then pointer wrap with automatic completions.
        flight_q.delete();
        auto_done     = 1'b1;
        bus_req_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(2'b11, 12'h100 + 12'(2 * i), 12'h101 + 12'(2 * i), 2'(i));
            if (i == 8) begin
                #1;
                check_eq("t4_ready_when_full", 32'(core_req_ready), 32'd0);
            end
            tick();
        end
        bus_req_ready = 1'b1;
        #1;
        check_eq("t4_ready_on_deq_cycle", 32'(core_req_ready), 32'd0);
        check_eq("t4_head_valid", 32'(bus_req_valid), 32'd1);
        tick();
        idle();
        wait_drain();
        for (int i = 0; i < 20; i++) begin
            v = 2'($urandom_range(1, 3));
            drive(v, 12'h200 + 12'(i), 12'h280 + 12'(i), 2'($urandom_range(0, 3)));
            bus_req_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle();
        bus_req_ready = 1'b1;
        wait_drain();
        auto_done = 1'b0;
        tick();
        bus_done_valid = 1'b0;

        // Allocation into way0[2] while a done frees way1[6].
        drive(2'b01, 12'h006, 12'h000, 2'b00);
        tick();
        drive(2'b10, 12'h000, 12'h046, 2'b00);
        tick();
        idle();
        tick();
        bus_req_ready = 1'b0;
        drive(2'b01, 12'h002, 12'h000, 2'b01);
        tick();
        idle();
        check_eq("t5_head_ready", 32'(bus_req_valid), 32'd1);
        bus_req_ready = 1'b1;
        done_pulse(12'h046);
        drive(2'b10, 12'h000, 12'h046, 2'b00);
        tick();
        idle();
        check_eq("t5_way1_freed", 32'(bus_req_valid), 32'd1);
        check_eq("t5_no_stall", 32'(conflict_stall), 32'd0);
        tick();
        drive(2'b01, 12'h002, 12'h000, 2'b00);
        tick();
        idle();
        check_eq("t5_way0_allocated", 32'(conflict_stall), 32'd1);
        done_pulse(12'h002);
        check_eq("t5_reissue", 32'(bus_req_valid), 32'd1);
        tick();
        done_pulse(12'h006);
        done_pulse(12'h046);
        done_pulse(12'h002);

        // Reset with 3 in flight and 5 queued.
        drive(2'b01, 12'h300, 12'h000, 2'b00);
        tick();
        drive(2'b10, 12'h000, 12'h301, 2'b00);
        tick();
        drive(2'b01, 12'h302, 12'h000, 2'b00);
        tick();
        idle();
        tick();
        bus_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(2'(1 << (i % 2)), 12'h310 + 12'(i), 12'h310 + 12'(i), 2'b00);
            tick();
        end
        idle();
        check_eq("t6_pre_reset_valid", 32'(bus_req_valid), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check_eq("t6_rst_valid", 32'(bus_req_valid), 32'd0);
        check_eq("t6_rst_stall", 32'(conflict_stall), 32'd0);
        check_eq("t6_rst_addr", 32'(bus_req_block_addr), 32'd0);
        check_eq("t6_rst_core", 32'(bus_req_core), 32'd0);
        check_eq("t6_rst_excl", 32'(bus_req_exclusive), 32'd0);
        @(posedge CLK);
        #3;
        nRST = 1'b1;
        drive(2'b01, 12'h300, 12'h000, 2'b01);
        tick();
        idle();
        check_eq("t6_no_false_conflict", 32'(bus_req_valid), 32'd1);
        check_eq("t6_no_stall", 32'(conflict_stall), 32'd0);
        bus_req_ready = 1'b1;
        tick();
        done_pulse(12'h300);
        tick();
        check_eq("final_scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
